// File: rtl/sa_host_master_pkg.sv
// sa_host_master_pkg: host command opcodes, FSM states and accelerator address map.
package sa_host_master_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_READ = 2'd1, OP_START = 2'd2, OP_RSVD = 2'd3} host_op_t;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_A, S_RD_D, S_START, S_RSP} state_t;
  localparam word_t SA_CFG_INPUT  = 32'hF0000;
  localparam word_t SA_CFG_WEIGHT = 32'hF0001;
  localparam word_t SA_CFG_OUTPUT = 32'hF0003;
  localparam word_t SA_START_ADDR = 32'h100000;
endpackage

// File: rtl/sa_host_master_if.sv
// sa_host_master_if: AW/W/AR/R slave-port signals of the accelerator.
interface sa_host_master_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              AWVALID, AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic              WDVALID, WDREADY;
  logic [DATA_W-1:0] WDATA;
  logic              ARVALID, ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              RDVALID, RDREADY;
  logic [DATA_W-1:0] RDATA;
  modport master (output AWVALID, AWADDR, WDVALID, WDATA, ARVALID, ARADDR, RDREADY,
                  input AWREADY, WDREADY, ARREADY, RDVALID, RDATA);
  modport slave  (input AWVALID, AWADDR, WDVALID, WDATA, ARVALID, ARADDR, RDREADY,
                  output AWREADY, WDREADY, ARREADY, RDVALID, RDATA);
endinterface

// File: rtl/sa_host_master.sv
// sa_host_master: turns WRITE/READ/START commands into accelerator bus handshakes with timeout.
module sa_host_master
  import sa_host_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  host_op_t          cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  sa_host_master_if.master  bus
);
  state_t      state_q;
  logic        aw_done_q, w_done_q;
  logic [31:0] cnt_q;
  logic        aw_hit, w_hit, busy, tmo, done, fin;
  always_comb begin
    aw_hit = bus.AWVALID & bus.AWREADY;
    w_hit  = bus.WDVALID & bus.WDREADY;
    busy   = state_q inside {S_WR, S_RD_A, S_RD_D, S_START};
    tmo    = busy && TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1);
    done   = state_q == S_WR    ? (aw_done_q | aw_hit) & (w_done_q | w_hit) :
             state_q == S_RD_D  ? bus.RDVALID :
             state_q == S_START ? bus.WDREADY : 1'b0;
    // a handshake landing on the last allowed cycle beats the timeout
    fin    = done | (tmo & ~(state_q == S_RD_A & bus.ARREADY));
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
      bus.AWVALID <= 1'b0;
      bus.AWADDR  <= '0;
      bus.WDVALID <= 1'b0;
      bus.WDATA   <= '0;
      bus.ARVALID <= 1'b0;
      bus.ARADDR  <= '0;
      bus.RDREADY <= 1'b0;
    end else begin
      cnt_q <= busy ? cnt_q + 32'd1 : '0;
      case (state_q)
        S_IDLE: if (cmd_valid && cmd_ready) begin
          cmd_ready <= 1'b0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          case (cmd_op)
            OP_WRITE: begin
              state_q     <= S_WR;
              bus.AWVALID <= 1'b1;
              bus.AWADDR  <= cmd_addr;
              bus.WDVALID <= 1'b1;
              bus.WDATA   <= cmd_data;
            end
            OP_READ: begin
              state_q     <= S_RD_A;
              bus.ARVALID <= 1'b1;
              bus.ARADDR  <= cmd_addr;
            end
            OP_START: begin
              state_q     <= S_START;
              bus.AWVALID <= 1'b1;
              bus.AWADDR  <= ADDR_W'(SA_START_ADDR);
            end
            default: begin
              state_q   <= S_RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          endcase
        end else cmd_ready <= 1'b1;
        S_WR: begin
          if (aw_hit) begin
            bus.AWVALID <= 1'b0;
            aw_done_q   <= 1'b1;
          end
          if (w_hit) begin
            bus.WDVALID <= 1'b0;
            w_done_q    <= 1'b1;
          end
        end
        S_RD_A: if (bus.ARREADY) begin
          state_q     <= S_RD_D;
          cnt_q       <= '0;
          bus.ARVALID <= 1'b0;
          bus.RDREADY <= 1'b1;
        end
        S_RSP: if (rsp_ready) begin
          state_q   <= S_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= '0;
        end
        default: ;
      endcase
      if (fin) begin
        state_q     <= S_RSP;
        cnt_q       <= '0;
        bus.AWVALID <= 1'b0;
        bus.WDVALID <= 1'b0;
        bus.ARVALID <= 1'b0;
        bus.RDREADY <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_err     <= ~done;
        rsp_data    <= (state_q == S_RD_D && done) ? bus.RDATA : '0;
      end
    end
  end
endmodule
